// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends one command/address/data frame as back-to-back 8N1 characters.
// Optional trailing XOR checksum byte: define UART_FRAME_TX_CHECKSUM_EN.
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_BYTES   = 2,
    parameter int DATA_BYTES   = 4,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [7:0]              i_command,
    input  logic [8*ADDR_BYTES-1:0] i_address,
    input  logic [8*DATA_BYTES-1:0] i_data,
    output logic                    o_serial,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int PAY_BYTES = ADDR_BYTES + DATA_BYTES;
`ifdef UART_FRAME_TX_CHECKSUM_EN
    localparam int B = 2 + PAY_BYTES;
`else
    localparam int B = 1 + PAY_BYTES;
`endif
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(B + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(B);

    // LOAD has no state of its own: the byte select happens on the
    // STOP->START edge so no extra line cycle is spent between characters.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             bit_idx;
    logic [IDX_W-1:0]       byte_idx;
    logic [7:0]             tx_byte;
    logic [8*PAY_BYTES-1:0] pay_sr;
    logic [8*PAY_BYTES-1:0] payload;
    logic [7:0]             next_byte;
    logic                   bit_end;
    logic                   more_bytes;

    assign bit_end    = (cnt == CNT_MAX);
    assign more_bytes = (byte_idx < IDX_LAST);

    // Reorder address and data into transmit order, lowest byte sent first.
    always_comb begin
        payload = '0;
        for (int k = 0; k < ADDR_BYTES; k++) begin
            if (MSB_FIRST)
                payload[8*k +: 8] = i_address[8*(ADDR_BYTES-1-k) +: 8];
            else
                payload[8*k +: 8] = i_address[8*k +: 8];
        end
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (MSB_FIRST)
                payload[8*(ADDR_BYTES+k) +: 8] = i_data[8*(DATA_BYTES-1-k) +: 8];
            else
                payload[8*(ADDR_BYTES+k) +: 8] = i_data[8*k +: 8];
        end
    end

`ifdef UART_FRAME_TX_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of every byte handed to the character shifter.
    always_ff @(posedge clock) begin
        if (reset)
            csum <= '0;
        else if (state == IDLE && i_valid)
            csum <= i_command;
        else if (state == STOP && bit_end && more_bytes)
            csum <= csum ^ next_byte;
    end

    assign next_byte = (byte_idx == IDX_W'(B - 1)) ? csum : pay_sr[7:0];
`else
    assign next_byte = pay_sr[7:0];
`endif

    // Frame FSM with registered line and handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_byte  <= '0;
            pay_sr   <= '0;
            o_serial <= 1'b1;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        pay_sr   <= payload;
                        tx_byte  <= i_command;
                        byte_idx <= IDX_W'(1);
                        cnt      <= '0;
                        o_serial <= 1'b0;
                        o_ready  <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        o_serial <= tx_byte[0];
                        tx_byte  <= tx_byte >> 1;
                        state    <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            o_serial <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            o_serial <= tx_byte[0];
                            tx_byte  <= tx_byte >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (more_bytes) begin
                            tx_byte  <= next_byte;
                            pay_sr   <= pay_sr >> 8;
                            byte_idx <= byte_idx + 1'b1;
                            o_serial <= 1'b0;
                            state    <= START;
                        end else begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_done  <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: randomized frames against a byte/bit-level line model.
// Three DUTs: CLKS_PER_BIT=4 MSB-first, 4 LSB-first, and 868 with a short frame.
`timescale 1ns/1ps
module tb_uart_frame_tx;

    localparam int CPB  = 4;
    localparam int SCPB = 868;
`ifdef UART_FRAME_TX_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        f_valid = 1'b0;
    logic [7:0]  f_cmd   = '0;
    logic [15:0] f_addr  = '0;
    logic [31:0] f_data  = '0;
    logic        m_ready, m_serial, m_busy, m_done;
    logic        l_ready, l_serial, l_busy, l_done;

    logic        s_valid = 1'b0;
    logic [7:0]  s_cmd   = '0;
    logic [7:0]  s_addr  = '0;
    logic [7:0]  s_data  = '0;
    logic        s_ready, s_serial, s_busy, s_done;

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .ADDR_BYTES(2), .DATA_BYTES(4), .MSB_FIRST(1'b1)) dut_m (
        .clock(clock), .reset(reset), .i_valid(f_valid), .o_ready(m_ready),
        .i_command(f_cmd), .i_address(f_addr), .i_data(f_data),
        .o_serial(m_serial), .o_busy(m_busy), .o_done(m_done)
    );

    uart_frame_tx #(.CLKS_PER_BIT(CPB), .ADDR_BYTES(2), .DATA_BYTES(4), .MSB_FIRST(1'b0)) dut_l (
        .clock(clock), .reset(reset), .i_valid(f_valid), .o_ready(l_ready),
        .i_command(f_cmd), .i_address(f_addr), .i_data(f_data),
        .o_serial(l_serial), .o_busy(l_busy), .o_done(l_done)
    );

    uart_frame_tx #(.CLKS_PER_BIT(SCPB), .ADDR_BYTES(1), .DATA_BYTES(1), .MSB_FIRST(1'b1)) dut_s (
        .clock(clock), .reset(reset), .i_valid(s_valid), .o_ready(s_ready),
        .i_command(s_cmd), .i_address(s_addr), .i_data(s_data),
        .o_serial(s_serial), .o_busy(s_busy), .o_done(s_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_bytes[$];
    bit         exp_wave[$];
    bit         wave_m[$];
    bit         wave_l[$];
    bit         cap_m[$];
    bit         cap_l[$];
    int         done_cyc;
    int         start_cyc;

    // Reference: list the frame bytes, then expand each into start/8 data/stop bits.
    task automatic model_frame(input logic [7:0] cmd, input logic [63:0] addr,
                               input logic [63:0] data, input int na, input int nd,
                               input bit msb, input int cpb);
        logic [7:0] x;
        exp_bytes.delete();
        exp_wave.delete();
        exp_bytes.push_back(cmd);
        for (int i = 0; i < na; i++)
            exp_bytes.push_back(8'(addr >> (8 * (msb ? na - 1 - i : i))));
        for (int i = 0; i < nd; i++)
            exp_bytes.push_back(8'(data >> (8 * (msb ? nd - 1 - i : i))));
        if (CS) begin
            x = '0;
            foreach (exp_bytes[i]) x = x ^ exp_bytes[i];
            exp_bytes.push_back(x);
        end
        foreach (exp_bytes[i]) begin
            for (int j = 0; j < 10; j++) begin
                bit v;
                v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_bytes[i][j-1];
                repeat (cpb) exp_wave.push_back(v);
            end
        end
    endtask

    function automatic logic [7:0] decode(input bit lsb_dut, input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            int idx;
            idx = (k * 10 + 1 + j) * CPB + CPB / 2;
            b[j] = lsb_dut ? cap_l[idx] : cap_m[idx];
        end
        return b;
    endfunction

    // Present a frame to both fast DUTs at the next edge and follow it to o_ready.
    task automatic run_fast(input logic [7:0] cmd, input logic [15:0] addr,
                            input logic [31:0] data, input bit poke, input bit hold,
                            input logic [7:0] h_cmd, input logic [15:0] h_addr,
                            input logic [31:0] h_data);
        int len, wbad, sbad, wk, sk;
        logic [1:0] wgot, wwant;
        logic [5:0] sgot;
        model_frame(cmd, {48'b0, addr}, {32'b0, data}, 2, 4, 1'b1, CPB);
        wave_m = exp_wave;
        model_frame(cmd, {48'b0, addr}, {32'b0, data}, 2, 4, 1'b0, CPB);
        wave_l = exp_wave;
        len = wave_m.size();
        cap_m.delete();
        cap_l.delete();
        wbad = 0; sbad = 0; wk = 0; sk = 0;
        wgot = '0; wwant = '0; sgot = '0;
        start_cyc = -1;
        f_cmd = cmd; f_addr = addr; f_data = data; f_valid = 1'b1;
        for (int k = 1; k <= len + 2; k++) begin
            @(negedge clock);
            if (k == 1) begin
                if (m_serial === 1'b0) start_cyc = cyc;
                f_valid = hold;
                f_cmd = hold ? h_cmd : 8'($urandom);
                f_addr = hold ? h_addr : 16'($urandom);
                f_data = hold ? h_data : $urandom;
            end
            if (poke && k == len / 2) begin
                f_valid = 1'b1;
                f_cmd = 8'($urandom); f_addr = 16'($urandom); f_data = $urandom;
            end
            if (poke && k == len / 2 + 1) f_valid = 1'b0;
            if (k <= len) begin
                cap_m.push_back(m_serial);
                cap_l.push_back(l_serial);
                if ({m_serial, l_serial} !== {wave_m[k-1], wave_l[k-1]}) begin
                    if (wbad == 0) begin
                        wk = k; wgot = {m_serial, l_serial};
                        wwant = {wave_m[k-1], wave_l[k-1]};
                    end
                    wbad++;
                end
                if ({m_busy, l_busy, m_ready, l_ready, m_done, l_done} !== 6'b110000) begin
                    if (sbad == 0) begin
                        sk = k; sgot = {m_busy, l_busy, m_ready, l_ready, m_done, l_done};
                    end
                    sbad++;
                end
            end else if (k == len + 1) begin
                done_cyc = cyc;
                n_cmp++;
                if ({m_serial, l_serial, m_done, l_done, m_busy, l_busy, m_ready, l_ready}
                    !== 8'b11110000) begin
                    n_bad++;
                    $display("FAIL done_cycle: ser/done/busy/ready(m,l)=%b want 11110000",
                             {m_serial, l_serial, m_done, l_done, m_busy, l_busy, m_ready, l_ready});
                end
            end else begin
                n_cmp++;
                if ({m_ready, l_ready, m_done, l_done, m_serial, l_serial} !== 6'b110011) begin
                    n_bad++;
                    $display("FAIL ready_return: ready/done/ser(m,l)=%b want 110011",
                             {m_ready, l_ready, m_done, l_done, m_serial, l_serial});
                end
            end
        end
        n_cmp++;
        if (wbad !== 0) begin
            n_bad++;
            $display("FAIL line_wave: %0d cycles differ, first k=%0d got(m,l)=%b want %b",
                     wbad, wk, wgot, wwant);
        end
        n_cmp++;
        if (sbad !== 0) begin
            n_bad++;
            $display("FAIL busy_status: %0d cycles differ, first k=%0d busy/ready/done(m,l)=%b want 110000",
                     sbad, sk, sgot);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({m_serial, m_ready, m_busy, m_done, l_serial, l_ready, l_busy, l_done,
             s_serial, s_ready, s_busy, s_done} !== 12'b110011001100) begin
            n_bad++;
            $display("FAIL reset_state: ser/ready/busy/done x3=%b want 110011001100",
                     {m_serial, m_ready, m_busy, m_done, l_serial, l_ready, l_busy, l_done,
                      s_serial, s_ready, s_busy, s_done});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        logic [7:0] want_m [8];
        logic [7:0] want_l [8];
        int nb;
        want_m = '{8'hAB, 8'h00, 8'h10, 8'h00, 8'hFF, 8'h12, 8'hCD, 8'h9B};
        want_l = '{8'hAB, 8'h10, 8'h00, 8'hCD, 8'h12, 8'hFF, 8'h00, 8'h9B};
        nb = CS ? 8 : 7;
        run_fast(8'hAB, 16'h0010, 32'h00FF12CD, 1'b0, 1'b0, 8'h0, 16'h0, 32'h0);
        n_cmp++;
        if (cap_m.size() !== (CS ? 320 : 280)) begin
            n_bad++;
            $display("FAIL basic_length: %0d cycles want %0d", cap_m.size(), CS ? 320 : 280);
        end
        for (int k = 0; k < nb; k++) begin
            n_cmp++;
            if (decode(1'b0, k) !== want_m[k]) begin
                n_bad++;
                $display("FAIL basic_msb_byte%0d: got %h want %h", k, decode(1'b0, k), want_m[k]);
            end
            n_cmp++;
            if (decode(1'b1, k) !== want_l[k]) begin
                n_bad++;
                $display("FAIL basic_lsb_byte%0d: got %h want %h", k, decode(1'b1, k), want_l[k]);
            end
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 4; f++) begin
            int gap;
            gap = $urandom_range(0, 5);
            f_valid = 1'b0;
            repeat (gap) begin
                @(negedge clock);
                n_cmp++;
                if ({m_serial, l_serial, m_ready, l_ready, m_busy, l_busy} !== 6'b111100) begin
                    n_bad++;
                    $display("FAIL idle_line: ser/ready/busy(m,l)=%b want 111100",
                             {m_serial, l_serial, m_ready, l_ready, m_busy, l_busy});
                end
            end
            run_fast(8'($urandom), 16'($urandom), $urandom, 1'b0, 1'b0, 8'h0, 16'h0, 32'h0);
        end
    endtask

    task automatic test_busy_ignore;
        run_fast(8'($urandom), 16'($urandom), $urandom, 1'b1, 1'b0, 8'h0, 16'h0, 32'h0);
        @(negedge clock);
        n_cmp++;
        if ({m_serial, l_serial, m_busy, l_busy} !== 4'b1100) begin
            n_bad++;
            $display("FAIL busy_no_queue: ser/busy(m,l)=%b want 1100",
                     {m_serial, l_serial, m_busy, l_busy});
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a2;
        logic [31:0] d2;
        int first_done;
        a2 = 16'($urandom);
        d2 = $urandom;
        run_fast(8'($urandom), 16'($urandom), $urandom, 1'b0, 1'b1, 8'h01, a2, d2);
        first_done = done_cyc;
        run_fast(8'h01, a2, d2, 1'b0, 1'b0, 8'h0, 16'h0, 32'h0);
        n_cmp++;
        if (start_cyc - first_done !== 2) begin
            n_bad++;
            $display("FAIL b2b_gap: start bit %0d cycles after done, want 2",
                     start_cyc - first_done);
        end
    endtask

    task automatic test_reset_mid;
        int kr;
        kr = 3 * 10 * CPB + 4 * CPB;
        f_cmd = 8'($urandom); f_addr = 16'($urandom); f_data = $urandom;
        f_valid = 1'b1;
        for (int k = 1; k <= kr; k++) begin
            @(negedge clock);
            f_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++;
        if ({m_serial, l_serial, m_ready, l_ready, m_busy, l_busy, m_done, l_done}
            !== 8'b11110000) begin
            n_bad++;
            $display("FAIL reset_abort: ser/ready/busy/done(m,l)=%b want 11110000",
                     {m_serial, l_serial, m_ready, l_ready, m_busy, l_busy, m_done, l_done});
        end
        begin
            int seen;
            seen = 0;
            repeat (40 * CPB) begin
                @(negedge clock);
                if (m_done || l_done || !m_serial || !l_serial) seen++;
            end
            n_cmp++;
            if (seen !== 0) begin
                n_bad++;
                $display("FAIL reset_quiet: %0d cycles with done or line low, want 0", seen);
            end
        end
        run_fast(8'($urandom), 16'($urandom), $urandom, 1'b0, 1'b0, 8'h0, 16'h0, 32'h0);
    endtask

    task automatic test_bit_timing;
        int len, nb, wbad, wk, run, rbad, pbad;
        logic prev;
        s_cmd = 8'($urandom); s_addr = 8'($urandom); s_data = 8'($urandom);
        model_frame(s_cmd, {56'b0, s_addr}, {56'b0, s_data}, 1, 1, 1'b1, SCPB);
        len = exp_wave.size();
        nb = exp_bytes.size();
        wbad = 0; wk = 0; run = 0; rbad = 0; pbad = 0;
        prev = 1'b1;
        s_valid = 1'b1;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clock);
            s_valid = 1'b0;
            if (k <= len) begin
                if (s_serial !== exp_wave[k-1]) begin
                    if (wbad == 0) wk = k;
                    wbad++;
                end
                if (k > 1 && s_serial !== prev) begin
                    if (run % SCPB != 0) rbad++;
                    run = 0;
                end
                run++;
                prev = s_serial;
                if ((k - 1) % (10 * SCPB) == 0 && s_serial !== 1'b0) pbad++;
                if (k % (10 * SCPB) == 0 && s_serial !== 1'b1) pbad++;
            end else begin
                n_cmp++;
                if ({s_done, s_serial, s_busy} !== 3'b110) begin
                    n_bad++;
                    $display("FAIL slow_done: done/ser/busy=%b want 110",
                             {s_done, s_serial, s_busy});
                end
            end
        end
        n_cmp++;
        if (len !== nb * 8680) begin
            n_bad++;
            $display("FAIL slow_frame_len: %0d want %0d", len, nb * 8680);
        end
        n_cmp++;
        if (wbad !== 0) begin
            n_bad++;
            $display("FAIL slow_wave: %0d cycles differ, first k=%0d", wbad, wk);
        end
        n_cmp++;
        if (rbad !== 0) begin
            n_bad++;
            $display("FAIL bit_length: %0d runs not a multiple of %0d", rbad, SCPB);
        end
        n_cmp++;
        if (pbad !== 0) begin
            n_bad++;
            $display("FAIL byte_period: %0d byte boundaries off the 8680-cycle grid", pbad);
        end
        @(negedge clock);
        n_cmp++;
        if ({s_ready, s_done} !== 2'b10) begin
            n_bad++;
            $display("FAIL slow_ready: ready/done=%b want 10", {s_ready, s_done});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_bit_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
